// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - scoreboard that snoops adder operands and checks returned results
// In-order expected-sum queue with pass/fail counters, sticky protocol flags and a latency watchdog.
module adder_result_checker #(
   parameter int WIDTH     = 8,
   parameter int RES_WIDTH = WIDTH + 1,
   parameter int DEPTH     = 8,
   parameter int TIMEOUT   = 64,
   parameter int CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_in,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic                         valid_out,
   input  logic [RES_WIDTH-1:0]         result,
   output logic [CNT_WIDTH-1:0]         pass_count,
   output logic [CNT_WIDTH-1:0]         fail_count,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding,
   output logic                         mismatch,
   output logic [RES_WIDTH-1:0]         exp_capture,
   output logic [RES_WIDTH-1:0]         act_capture,
   output logic                         err_overflow,
   output logic                         err_unexpected,
   output logic                         err_timeout,
   output logic                         idle
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

   state_t                state, state_nx;
   logic [RES_WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [OW-1:0]         count;
   logic [WW-1:0]         wd, wd_nx;
   logic [RES_WIDTH-1:0]  sum, head;
   logic                  empty, full, pop, push, match, timeout_nx;

   assign sum   = RES_WIDTH'(a) + RES_WIDTH'(b);
   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == OW'(DEPTH));
   assign pop   = valid_out && !empty;
   // A same-cycle pop frees the slot, so a push into a full queue is still accepted.
   assign push  = valid_in && (!full || pop);
   assign match = (result == head);

   assign outstanding = count;
   assign idle        = (state == IDLE);

   always_comb begin
      wd_nx = wd;
      if (pop || empty)
         wd_nx = '0;
      else if (wd != WW'(TIMEOUT))
         wd_nx = wd + WW'(1);
   end

   assign timeout_nx = (wd_nx == WW'(TIMEOUT));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (push) state_nx = WAIT;
         WAIT:    if (pop && !push && count == OW'(1)) state_nx = IDLE;
         ERROR:   state_nx = ERROR;
         default: state_nx = IDLE;
      endcase
      if (timeout_nx)
         state_nx = ERROR;
   end

   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         wd             <= '0;
         pass_count     <= '0;
         fail_count     <= '0;
         mismatch       <= 1'b0;
         exp_capture    <= '0;
         act_capture    <= '0;
         err_overflow   <= 1'b0;
         err_unexpected <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         state    <= state_nx;
         wd       <= wd_nx;
         mismatch <= pop && !match;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + OW'(1);
         else if (pop && !push)
            count <= count - OW'(1);
         if (pop && match && pass_count != '1)
            pass_count <= pass_count + CNT_WIDTH'(1);
         if (pop && !match) begin
            if (fail_count != '1)
               fail_count <= fail_count + CNT_WIDTH'(1);
            exp_capture <= head;
            act_capture <= result;
         end
         if (valid_in && !push)
            err_overflow <= 1'b1;
         if (valid_out && empty)
            err_unexpected <= 1'b1;
         if (timeout_nx)
            err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adder_result_checker.sv
// tb/tb_adder_result_checker.sv - scoreboard bench for adder_result_checker
// Driver keeps a queue-level model; a monitor checks capture values on every mismatch pulse.
module tb_adder_result_checker;

   localparam int WIDTH = 8, RW = 9, DEPTH = 8, TIMEOUT = 64, CW = 16;
   localparam int RMASK = (1 << RW) - 1, CMAX = (1 << CW) - 1;

   logic          clk = 1'b0, rst = 1'b1;
   logic          valid_in = 1'b0, valid_out = 1'b0;
   logic [7:0]    a = '0, b = '0;
   logic [8:0]    result = '0;
   logic [15:0]   pass_count, fail_count;
   logic [3:0]    outstanding;
   logic          mismatch, err_overflow, err_unexpected, err_timeout, idle;
   logic [8:0]    exp_capture, act_capture;

   adder_result_checker #(.WIDTH(WIDTH), .RES_WIDTH(RW), .DEPTH(DEPTH),
                          .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b),
      .valid_out(valid_out), .result(result),
      .pass_count(pass_count), .fail_count(fail_count), .outstanding(outstanding),
      .mismatch(mismatch), .exp_capture(exp_capture), .act_capture(act_capture),
      .err_overflow(err_overflow), .err_unexpected(err_unexpected),
      .err_timeout(err_timeout), .idle(idle));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   int q[$];
   int mm_exp[$], mm_act[$];
   int m_pass, m_fail, m_ovf, m_unx, m_to, m_mm, m_expc, m_actc, m_stall;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete(); mm_exp.delete(); mm_act.delete();
      m_pass = 0; m_fail = 0; m_ovf = 0; m_unx = 0; m_to = 0;
      m_mm = 0; m_expc = 0; m_actc = 0; m_stall = 0;
   endtask

   task automatic step(input logic vi, input int ai, input int bi,
                       input logic vo, input int r, input logic rs);
      bit was_empty, popped;
      int h;
      rst = rs; valid_in = vi; a = ai[7:0]; b = bi[7:0]; valid_out = vo; result = r[8:0];
      if (rs) begin
         model_reset();
      end else begin
         was_empty = (q.size() == 0);
         popped = 0;
         m_mm = 0;
         if (vo && !was_empty) begin
            popped = 1;
            h = q.pop_front();
            if ((r & RMASK) == h) begin
               m_pass = (m_pass == CMAX) ? CMAX : m_pass + 1;
            end else begin
               m_fail = (m_fail == CMAX) ? CMAX : m_fail + 1;
               m_mm = 1; m_expc = h; m_actc = r & RMASK;
               mm_exp.push_back(h); mm_act.push_back(r & RMASK);
            end
         end else if (vo) begin
            m_unx = 1;
         end
         if (vi) begin
            if (q.size() < DEPTH) q.push_back((ai + bi) & RMASK);
            else m_ovf = 1;
         end
         // Cycles an expectation has waited without any result arriving
         if (popped || was_empty) m_stall = 0;
         else if (m_stall < TIMEOUT) m_stall++;
         if (m_stall == TIMEOUT) m_to = 1;
      end
      @(posedge clk);
      #1;
      chk("pass_count", pass_count, m_pass);
      chk("fail_count", fail_count, m_fail);
      chk("outstanding", outstanding, q.size());
      chk("mismatch", mismatch, m_mm);
      chk("exp_capture", exp_capture, m_expc);
      chk("act_capture", act_capture, m_actc);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_unexpected", err_unexpected, m_unx);
      chk("err_timeout", err_timeout, m_to);
      chk("idle", idle, (q.size() == 0 && !m_to) ? 1 : 0);
      @(negedge clk);
   endtask

   function automatic int head_or(input int dflt);
      return (q.size() > 0) ? q[0] : dflt;
   endfunction

   always @(posedge clk) begin
      #2;
      if (mismatch) begin
         if (mm_exp.size() == 0) begin
            chk("mon_unexpected_pulse", 1, 0);
         end else begin
            chk("mon_exp_capture", exp_capture, mm_exp.pop_front());
            chk("mon_act_capture", act_capture, mm_act.pop_front());
         end
      end
   end

   initial begin
      int r;
      model_reset();
      @(negedge clk);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      step(1, 3, 4, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 7, 0);
      chk("t1_pass", pass_count, 1);
      chk("t1_idle", idle, 1);

      step(1, 255, 1, 0, 0, 0);
      step(0, 0, 0, 1, 9'h100, 0);
      step(1, 10, 20, 0, 0, 0);
      step(0, 0, 0, 1, 31, 0);
      chk("t2_fail", fail_count, 1);
      chk("t2_exp_capture", exp_capture, 30);
      chk("t2_act_capture", act_capture, 31);

      for (int i = 0; i < 8; i++) step(1, i, i + 1, 0, 0, 0);
      chk("t3_full", outstanding, 8);
      step(1, 1, 1, 0, 0, 0);
      chk("t3_overflow", err_overflow, 1);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, i, 2, 0, 0, 0);
      step(1, 2, 2, 1, head_or(0), 0);
      chk("t3_push_pop_full", outstanding, 8);
      chk("t3_no_overflow", err_overflow, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, head_or(0), 0);

      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 5, 0);
      chk("t4_unexpected", err_unexpected, 1);
      chk("t4_no_count", pass_count + fail_count, 0);
      step(1, 1, 2, 1, 9, 0);
      chk("t4_push_kept", outstanding, 1);
      step(0, 0, 0, 1, 3, 0);

      step(0, 0, 0, 0, 0, 1);
      step(1, 40, 2, 0, 0, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, 0, 0);
      chk("t5_not_yet", err_timeout, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("t5_timeout", err_timeout, 1);
      chk("t5_not_idle", idle, 0);
      step(0, 0, 0, 1, 42, 0);
      chk("t5_late_pass", pass_count, 1);

      for (int i = 0; i < 5; i++) step(1, i, 7, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t6_reset_out", outstanding, 0);
      chk("t6_reset_idle", idle, 1);
      step(1, 100, 27, 0, 0, 0);
      step(0, 0, 0, 1, 127, 0);
      chk("t6_pass", pass_count, 1);

      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 500; i++) begin
         logic vi, vo;
         vi = ($urandom_range(0, 3) != 0);
         vo = ($urandom_range(0, 2) != 0);
         r = head_or($urandom_range(0, RMASK));
         if ($urandom_range(0, 7) == 0) r = r ^ (1 << $urandom_range(0, RW - 1));
         step(vi, $urandom_range(0, 255), $urandom_range(0, 255), vo, r, 0);
      end
      step(0, 0, 0, 0, 0, 0);
      chk("mon_drained", mm_exp.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
